// File: rtl/traffic_pkg.sv
// Shared phase encoding, lamp bundle types and default timing for the
// two-road traffic phase sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_ALL_RED_A = 3'd0,
        PH_NS_GREEN  = 3'd1,
        PH_NS_YELLOW = 3'd2,
        PH_ALL_RED_B = 3'd3,
        PH_EW_GREEN  = 3'd4,
        PH_EW_YELLOW = 3'd5
    } phase_e;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    typedef struct packed {
        lamp_t ns;
        lamp_t ew;
    } lamp_pair_t;

    localparam lamp_t LAMP_RED    = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    localparam lamp_t LAMP_YELLOW = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
    localparam lamp_t LAMP_GREEN  = '{red: 1'b0, yellow: 1'b0, green: 1'b1};

    localparam int DEF_TICK_DIV     = 50_000_000;
    localparam int DEF_NS_GREEN_MIN = 8;
    localparam int DEF_EW_GREEN_MIN = 4;
    localparam int DEF_EW_GREEN_MAX = 16;
    localparam int DEF_YELLOW_TIME  = 4;
    localparam int DEF_ALL_RED_TIME = 1;

    localparam int TIMER_W = 5;

    // Any road not explicitly given green/yellow stays red, so illegal codes
    // and both all-red phases decode to red on both roads.
    function automatic lamp_pair_t decode_lamps(phase_e ph);
        lamp_pair_t lp;
        lp.ns = LAMP_RED;
        lp.ew = LAMP_RED;
        case (ph)
            PH_NS_GREEN:  lp.ns = LAMP_GREEN;
            PH_NS_YELLOW: lp.ns = LAMP_YELLOW;
            PH_EW_GREEN:  lp.ew = LAMP_GREEN;
            PH_EW_YELLOW: lp.ew = LAMP_YELLOW;
            default:      ;
        endcase
        return lp;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick pulse every TICK_DIV cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so that TICK_DIV=1 yields a tick on every cycle.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// NS-rest, EW-actuated phase sequencer: detector synchronizers, EW request
// latch, per-phase tick timer, phase FSM and registered lamp drivers.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int NS_GREEN_MIN = DEF_NS_GREEN_MIN,
    parameter int EW_GREEN_MIN = DEF_EW_GREEN_MIN,
    parameter int EW_GREEN_MAX = DEF_EW_GREEN_MAX,
    parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int ALL_RED_TIME = DEF_ALL_RED_TIME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NS_VEHICLE_DETECT,
    input  logic       EW_VEHICLE_DETECT,
    output logic       NS_RED,
    output logic       NS_YELLOW,
    output logic       NS_GREEN,
    output logic       EW_RED,
    output logic       EW_YELLOW,
    output logic       EW_GREEN,
    output logic [2:0] phase,
    output logic [4:0] phase_timer
);

    // Thresholds are compared against the pre-increment timer, hence N-1.
    localparam logic [TIMER_W-1:0] ALL_RED_LAST = TIMER_W'(ALL_RED_TIME - 1);
    localparam logic [TIMER_W-1:0] NS_MIN_LAST  = TIMER_W'(NS_GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] EW_MIN_LAST  = TIMER_W'(EW_GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] EW_MAX_LAST  = TIMER_W'(EW_GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST  = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] TIMER_SAT    = '1;

    logic tick;

    logic ew_meta_q, ew_meta_d;
    logic ew_sync_q, ew_sync_d;
    logic ns_meta_q, ns_meta_d;
    logic ns_sync_q, ns_sync_d;
    logic ew_req_q, ew_req_d;
    phase_e state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    lamp_t ns_lamp_q, ns_lamp_d;
    lamp_t ew_lamp_q, ew_lamp_d;
    lamp_pair_t lamps_next;

    // Synchronized NS detect has no consumer yet; held for future NS actuation.
    logic ns_det_unused;
    assign ns_det_unused = ns_sync_q;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        ew_meta_d = EW_VEHICLE_DETECT;
        ew_sync_d = ew_meta_q;
        ns_meta_d = NS_VEHICLE_DETECT;
        ns_sync_d = ns_meta_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_ALL_RED_A: if (tick && timer_q >= ALL_RED_LAST) state_d = PH_NS_GREEN;
            PH_NS_GREEN:  if (tick && timer_q >= NS_MIN_LAST && ew_req_q) state_d = PH_NS_YELLOW;
            PH_NS_YELLOW: if (tick && timer_q >= YELLOW_LAST) state_d = PH_ALL_RED_B;
            PH_ALL_RED_B: if (tick && timer_q >= ALL_RED_LAST) state_d = PH_EW_GREEN;
            PH_EW_GREEN: begin
                if (tick && (timer_q >= EW_MAX_LAST ||
                             (timer_q >= EW_MIN_LAST && !ew_sync_q))) begin
                    state_d = PH_EW_YELLOW;
                end
            end
            PH_EW_YELLOW: if (tick && timer_q >= YELLOW_LAST) state_d = PH_ALL_RED_A;
            // Illegal codes recover without waiting for a tick.
            default:      state_d = PH_ALL_RED_A;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && timer_q != TIMER_SAT) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Entry into EW green consumes the request and wins over a same-cycle set.
    always_comb begin
        ew_req_d = ew_req_q;
        if (state_d == PH_EW_GREEN && state_q != PH_EW_GREEN) begin
            ew_req_d = 1'b0;
        end else if (ew_sync_q && state_q != PH_EW_GREEN) begin
            ew_req_d = 1'b1;
        end
    end

    always_comb begin
        lamps_next = decode_lamps(state_d);
        ns_lamp_d  = lamps_next.ns;
        ew_lamp_d  = lamps_next.ew;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ew_meta_q <= 1'b0;
            ew_sync_q <= 1'b0;
            ns_meta_q <= 1'b0;
            ns_sync_q <= 1'b0;
            ew_req_q  <= 1'b0;
            state_q   <= PH_ALL_RED_A;
            timer_q   <= '0;
            ns_lamp_q <= LAMP_RED;
            ew_lamp_q <= LAMP_RED;
        end else begin
            ew_meta_q <= ew_meta_d;
            ew_sync_q <= ew_sync_d;
            ns_meta_q <= ns_meta_d;
            ns_sync_q <= ns_sync_d;
            ew_req_q  <= ew_req_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            ns_lamp_q <= ns_lamp_d;
            ew_lamp_q <= ew_lamp_d;
        end
    end

    assign NS_RED      = ns_lamp_q.red;
    assign NS_YELLOW   = ns_lamp_q.yellow;
    assign NS_GREEN    = ns_lamp_q.green;
    assign EW_RED      = ew_lamp_q.red;
    assign EW_YELLOW   = ew_lamp_q.yellow;
    assign EW_GREEN    = ew_lamp_q.green;
    assign phase       = state_q;
    assign phase_timer = timer_q;

endmodule
